// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the integer clock divider.
package clk_div_pkg;

    // Default counter / divisor width.
    localparam int CNT_W_DEF = 28;

    // Smallest usable divide ratio; anything below behaves as this.
    localparam int DIV_MIN = 2;

    typedef logic [CNT_W_DEF-1:0] div_t;

    // Clamp a raw divisor to the smallest ratio the divider can produce.
    function automatic div_t eff_div(input div_t n);
        return (n < div_t'(DIV_MIN)) ? div_t'(DIV_MIN) : n;
    endfunction

endpackage

// File: rtl/clk_divider.sv
// Synchronous integer clock divider with glitch-free run-time reload and
// rise/fall edge strobes in the master clock domain.
module clk_divider
    import clk_div_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIVISOR = CNT_W'(4)
) (
    input  logic             clock_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    output logic             clock_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] div_active
);

    // Clamp a raw divisor at this instance's counter width.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] n);
        return (n < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : n;
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_act;
    logic [CNT_W-1:0] n_pend;
    logic             pend_vld;

    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] n_half;
    logic             wrap;
    logic [CNT_W-1:0] cnt_next;

    // Next-count arithmetic; cnt never exceeds n_eff-1, so cnt+1 cannot overflow.
    always_comb begin
        n_eff    = clamp_div(n_act);
        n_half   = n_eff >> 1;
        wrap     = (cnt == n_eff - CNT_W'(1));
        cnt_next = wrap ? '0 : cnt + CNT_W'(1);
    end

    // Counter, divided output, edge strobes and divisor switch at the period boundary.
    always_ff @(posedge clock_in) begin
        if (rst) begin
            cnt       <= '0;
            clock_out <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
            n_act     <= DIVISOR;
        end else if (enable) begin
            cnt       <= cnt_next;
            clock_out <= (cnt_next >= n_half);
            rise_tick <= (cnt_next == n_half);
            fall_tick <= wrap;
            if (wrap && pend_vld) begin
                n_act <= n_pend;
            end
        end else begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end
    end

    // Pending-divisor capture; a load in the wrap cycle stays pending for the next wrap.
    always_ff @(posedge clock_in) begin
        if (rst) begin
            n_pend   <= DIVISOR;
            pend_vld <= 1'b0;
        end else if (div_load) begin
            n_pend   <= div_value;
            pend_vld <= 1'b1;
        end else if (enable && wrap) begin
            pend_vld <= 1'b0;
        end
    end

    assign div_active = n_act;

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider against a waveform-queue reference model.
module tb_clk_divider;

    localparam int          W   = 28;
    localparam logic [W-1:0] DIV = 28'd4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         div_load = 1'b0;
    logic [W-1:0] div_value = '0;
    logic         clock_out;
    logic         rise_tick;
    logic         fall_tick;
    logic [W-1:0] div_active;

    int errors = 0;
    int checks = 0;

    // Reference model: the remaining output samples of the current period.
    int           q[$];
    logic [W-1:0] m_nact;
    logic [W-1:0] m_npend;
    bit           m_pvld;
    bit           m_out;
    bit           m_rise;
    bit           m_fall;

    logic [W+2:0] got;
    logic [W+2:0] exp;

    clk_divider #(.CNT_W(W), .DIVISOR(DIV)) dut (
        .clock_in  (clk),
        .rst       (rst),
        .enable    (enable),
        .div_load  (div_load),
        .div_value (div_value),
        .clock_out (clock_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .div_active(div_active)
    );

    always #5 clk = ~clk;

    // One full period of output samples: floor(N/2) low, ceil(N/2) high.
    task automatic fill(input logic [W-1:0] n);
        int e;
        e = (n < 2) ? 2 : int'(n);
        for (int i = 0; i < e / 2; i++) q.push_back(0);
        for (int i = 0; i < e - e / 2; i++) q.push_back(1);
    endtask

    task automatic model_reset();
        q.delete();
        m_nact  = DIV;
        m_npend = DIV;
        m_pvld  = 0;
        m_out   = 0;
        m_rise  = 0;
        m_fall  = 0;
        fill(DIV);
        void'(q.pop_front());
    endtask

    // Advance one clock, update the model from the inputs seen at that edge.
    task automatic step();
        bit wrapped;
        bit nxt;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            wrapped = 0;
            if (enable) begin
                if (q.size() == 0) begin
                    wrapped = 1;
                    if (m_pvld) m_nact = m_npend;
                    fill(m_nact);
                end
                nxt    = q.pop_front() != 0;
                m_rise = nxt && !m_out;
                m_fall = !nxt && m_out;
                m_out  = nxt;
            end else begin
                m_rise = 0;
                m_fall = 0;
            end
            if (div_load) begin
                m_npend = div_value;
                m_pvld  = 1;
            end else if (enable && wrapped) begin
                m_pvld = 0;
            end
        end
        #1;
        got = {clock_out, rise_tick, fall_tick, div_active};
        exp = {m_out, m_rise, m_fall, m_nact};
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; div_load = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; div_load = 1'b0;
        step();
        step();
        checks++;
        if (got !== {1'b0, 1'b0, 1'b0, DIV}) begin
            errors++;
            $display("FAIL reset: got out/rise/fall/div=%h want %h", got, {1'b0, 1'b0, 1'b0, DIV});
        end
        rst = 1'b0;
    endtask

    task automatic test_div4();
        bit pat [4];
        pat = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (got !== exp || clock_out !== pat[i % 4]) begin
                errors++;
                $display("FAIL div4 cyc %0d: got %h want %h (pattern bit %b)", i, got, exp, pat[i % 4]);
            end
        end
    endtask

    task automatic test_div5();
        int high_run;
        int high_max;
        do_reset();
        div_load = 1'b1; div_value = 28'd5;
        step();
        div_load = 1'b0;
        high_run = 0; high_max = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            high_run = clock_out ? high_run + 1 : 0;
            if (high_run > high_max) high_max = high_run;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL div5 cyc %0d: got %h want %h", i, got, exp);
            end
        end
        checks++;
        if (high_max != 3 || div_active !== 28'd5) begin
            errors++;
            $display("FAIL div5 high phase: got %0d cycles div=%0d want 3 cycles div=5", high_max, div_active);
        end
    endtask

    task automatic test_div1();
        do_reset();
        div_load = 1'b1; div_value = 28'd1;
        step();
        div_load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL div1 cyc %0d: got %h want %h", i, got, exp);
            end
        end
        checks++;
        if (div_active !== 28'd1) begin
            errors++;
            $display("FAIL div1 active: got %0d want 1", div_active);
        end
    endtask

    task automatic test_reload_mid();
        do_reset();
        step();
        div_load = 1'b1; div_value = 28'd6;
        step();
        div_load = 1'b0;
        step();
        checks++;
        if (div_active !== DIV || clock_out !== 1'b1) begin
            errors++;
            $display("FAIL reload before wrap: got div=%0d out=%b want div=4 out=1", div_active, clock_out);
        end
        step();
        checks++;
        if (div_active !== 28'd6 || fall_tick !== 1'b1) begin
            errors++;
            $display("FAIL reload wrap edge: got div=%0d fall=%b want div=6 fall=1", div_active, fall_tick);
        end
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reload cyc %0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_load_in_wrap();
        do_reset();
        step(); step(); step();
        div_load = 1'b1; div_value = 28'd3;
        step();
        div_load = 1'b0;
        checks++;
        if (div_active !== DIV) begin
            errors++;
            $display("FAIL wrap-cycle load applied early: got div=%0d want 4", div_active);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wrap-load cyc %0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_enable_freeze();
        do_reset();
        step(); step();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (got !== {1'b1, 1'b0, 1'b0, DIV} || got !== exp) begin
                errors++;
                $display("FAIL freeze cyc %0d: got %h want %h", i, got, exp);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL resume cyc %0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        div_load = 1'b1; div_value = 28'd7;
        step();
        div_load = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (got !== {1'b0, 1'b0, 1'b0, DIV}) begin
            errors++;
            $display("FAIL mid reset: got %h want %h", got, {1'b0, 1'b0, 1'b0, DIV});
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (got !== exp || div_active !== DIV) begin
                errors++;
                $display("FAIL after mid reset cyc %0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            enable    = ($urandom_range(0, 4) != 0);
            div_load  = ($urandom_range(0, 9) == 0);
            div_value = W'($urandom_range(0, 9));
            rst       = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, got, exp);
            end
        end
        rst = 1'b0; div_load = 1'b0; enable = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_div4();
        test_div5();
        test_div1();
        test_reload_mid();
        test_load_in_wrap();
        test_enable_freeze();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
